// File: rtl/led_uart_frame_loader.sv
// led_uart_frame_loader: 8N1 UART receiver and row-packet parser producing frame buffer write strobes.
// Optional LED_UART_CHECKSUM_EN: trailing XOR checksum byte, buffered row, burst commit on match.
module led_uart_frame_loader #(
  parameter int CLKS_PER_BIT = 20,
  parameter int ROWS = 8,
  parameter int ROW_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         uart_data,
  output logic                         fb_we,
  output logic [$clog2(ROWS)-1:0]      fb_row,
  output logic [$clog2(ROW_BYTES)-1:0] fb_col,
  output logic [7:0]                   fb_data,
  output logic                         row_done,
  output logic                         rx_error
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROW_BYTES);
  localparam int NW = $clog2(CLKS_PER_BIT);
  localparam logic [NW-1:0] FULL = NW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] HALF = NW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(ROW_BYTES - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_t;
  typedef enum logic [2:0] {P_SYNC, P_ROW, P_DATA, P_CSUM, P_COMMIT} p_t;

`ifdef LED_UART_CHECKSUM_EN
  localparam p_t AFTER_DATA = P_CSUM;
`else
  localparam p_t AFTER_DATA = P_SYNC;
`endif

  logic          s1, s2;
  rx_t           rx_state, rx_next;
  logic [NW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          byte_valid, frame_err;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      s1       <= uart_data;
      s2       <= s1;
      rx_state <= rx_next;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
    end

  always_comb begin
    rx_next    = rx_state;
    cnt_n      = cnt + 1'b1;
    bit_n      = bit_idx;
    shift_n    = shift;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_n = '0;
        if (!s2) rx_next = RX_START;
      end
      RX_START:
        if (cnt == HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          rx_next = s2 ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (cnt == FULL) begin
          cnt_n   = '0;
          shift_n = {s2, shift[7:1]};
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) rx_next = RX_STOP;
        end
      RX_STOP:
        if (cnt == FULL) begin
          cnt_n      = '0;
          byte_valid = s2;
          frame_err  = !s2;
          rx_next    = s2 ? RX_IDLE : RX_WAIT_IDLE;
        end
      default: begin
        cnt_n = '0;
        if (s2) rx_next = RX_IDLE;
      end
    endcase
  end

  p_t            p_state, p_next;
  logic [RW-1:0] row, row_n, fb_row_n;
  logic [CW-1:0] col, col_n, fb_col_n;
  logic [7:0]    fb_data_n;
  logic          we_n, err_n;

`ifdef LED_UART_CHECKSUM_EN
  logic [7:0] mem [ROW_BYTES];
  logic [7:0] csum, csum_n;
  logic       mem_we;

  always_ff @(posedge clk)
    if (mem_we) mem[col] <= shift;
`endif

  always_comb begin
    p_next    = p_state;
    row_n     = row;
    col_n     = col;
    we_n      = 1'b0;
    err_n     = frame_err;
    fb_row_n  = fb_row;
    fb_col_n  = fb_col;
    fb_data_n = fb_data;
`ifdef LED_UART_CHECKSUM_EN
    csum_n = csum;
    mem_we = 1'b0;
`endif
    if (frame_err)
      p_next = P_SYNC;
`ifdef LED_UART_CHECKSUM_EN
    else if (p_state == P_COMMIT) begin
      we_n      = 1'b1;
      fb_row_n  = row;
      fb_col_n  = col;
      fb_data_n = mem[col];
      col_n     = col + 1'b1;
      if (col == LAST) p_next = P_SYNC;
    end
`endif
    else if (byte_valid)
      case (p_state)
        P_SYNC: if (shift == SYNC_BYTE) p_next = P_ROW;
        P_ROW:
          if (32'(shift) < ROWS) begin
            row_n  = RW'(shift);
            col_n  = '0;
            p_next = P_DATA;
`ifdef LED_UART_CHECKSUM_EN
            csum_n = shift;
`endif
          end else begin
            err_n  = 1'b1;
            p_next = P_SYNC;
          end
        P_DATA: begin
`ifdef LED_UART_CHECKSUM_EN
          mem_we = 1'b1;
          csum_n = csum ^ shift;
`else
          we_n      = 1'b1;
          fb_row_n  = row;
          fb_col_n  = col;
          fb_data_n = shift;
`endif
          col_n = col + 1'b1;
          if (col == LAST) p_next = AFTER_DATA;
        end
`ifdef LED_UART_CHECKSUM_EN
        // col 0 goes out with the checksum so the burst starts one cycle after it
        P_CSUM:
          if (shift == csum) begin
            we_n      = 1'b1;
            fb_row_n  = row;
            fb_col_n  = '0;
            fb_data_n = mem[0];
            col_n     = CW'(1);
            p_next    = P_COMMIT;
          end else begin
            err_n  = 1'b1;
            p_next = P_SYNC;
          end
`endif
        default: ;
      endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p_state  <= P_SYNC;
      row      <= '0;
      col      <= '0;
      fb_we    <= 1'b0;
      fb_row   <= '0;
      fb_col   <= '0;
      fb_data  <= '0;
      row_done <= 1'b0;
      rx_error <= 1'b0;
`ifdef LED_UART_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      p_state  <= p_next;
      row      <= row_n;
      col      <= col_n;
      fb_we    <= we_n;
      fb_row   <= fb_row_n;
      fb_col   <= fb_col_n;
      fb_data  <= fb_data_n;
      row_done <= fb_we && fb_col == LAST;
      rx_error <= err_n;
`ifdef LED_UART_CHECKSUM_EN
      csum     <= csum_n;
`endif
    end
endmodule

// File: tb/tb_led_uart_frame_loader.sv
// tb_led_uart_frame_loader: bench for led_uart_frame_loader (honours LED_UART_CHECKSUM_EN).
module tb_led_uart_frame_loader;
  localparam int CPB = 20, ROWS = 8, RB = 4;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0, reset = 1'b1, uart_data = 1'b1;
  logic       fb_we, row_done, rx_error;
  logic [2:0] fb_row;
  logic [1:0] fb_col;
  logic [7:0] fb_data;

  int checks = 0, errors = 0;
  logic [12:0] exp_w[$], obs_w[$];
  int exp_done = 0, exp_err = 0, obs_done = 0, obs_err = 0;
  int run = 0, max_run = 0, rd_bad = 0;
  logic prev_last = 1'b0;

  led_uart_frame_loader #(.CLKS_PER_BIT(CPB), .ROWS(ROWS), .ROW_BYTES(RB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .uart_data(uart_data), .fb_we(fb_we), .fb_row(fb_row),
    .fb_col(fb_col), .fb_data(fb_data), .row_done(row_done), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset) begin
      prev_last = 1'b0;
      run = 0;
    end else begin
      if (fb_we) obs_w.push_back({fb_row, fb_col, fb_data});
      if (row_done) obs_done++;
      if (rx_error) obs_err++;
      if (row_done !== prev_last) rd_bad++;
      prev_last = fb_we && fb_col == 2'd3;
      run = fb_we ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_data = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_data = b[i];
      wait_clks(CPB);
    end
    uart_data = 1'b1;
    wait_clks(CPB);
  endtask

  task automatic send(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic app(inout bq_t q, input bq_t p);
    foreach (p[i]) q.push_back(p[i]);
  endtask

  function automatic bq_t pkt(input logic [7:0] r, input logic [31:0] d);
    bq_t q;
    q.push_back(8'hA5);
    q.push_back(r);
    for (int i = 0; i < RB; i++) q.push_back(d[31-8*i -: 8]);
`ifdef LED_UART_CHECKSUM_EN
    begin
      logic [7:0] c;
      c = r;
      for (int i = 0; i < RB; i++) c ^= d[31-8*i -: 8];
      q.push_back(c);
    end
`endif
    return q;
  endfunction

  // Expected writes/row_done/rx_error for a byte stream, starting from an idle parser.
  task automatic model(input bq_t q);
    int i, n;
    logic [7:0] r;
    i = 0;
    n = q.size();
    while (i < n) begin
      if (q[i] != 8'hA5 || i + 1 >= n) begin
        i++;
        continue;
      end
      r = q[i+1];
      if (r >= ROWS) begin
        exp_err++;
        i += 2;
        continue;
      end
`ifdef LED_UART_CHECKSUM_EN
      if (i + 2 + RB < n) begin
        logic [7:0] c;
        c = r;
        for (int k = 0; k < RB; k++) c ^= q[i+2+k];
        if (c == q[i+2+RB]) begin
          for (int k = 0; k < RB; k++) exp_w.push_back({r[2:0], 2'(k), q[i+2+k]});
          exp_done++;
        end else exp_err++;
      end
      i += 3 + RB;
`else
      for (int k = 0; k < RB && i + 2 + k < n; k++) exp_w.push_back({r[2:0], 2'(k), q[i+2+k]});
      if (i + 1 + RB < n) exp_done++;
      i += 2 + RB;
`endif
    end
  endtask

  task automatic compare(input string tag);
    wait_clks(3 * CPB);
    chk({tag, " nwrites"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) chk({tag, " write"}, obs_w[i], exp_w[i]);
    chk({tag, " row_done"}, obs_done, exp_done);
    chk({tag, " rx_error"}, obs_err, exp_err);
    obs_w.delete();
    exp_w.delete();
    obs_done = 0;
    obs_err = 0;
    exp_done = 0;
    exp_err = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, " fb_we"}, fb_we, 0);
    chk({tag, " row_done"}, row_done, 0);
    chk({tag, " rx_error"}, rx_error, 0);
    chk({tag, " fb_row"}, fb_row, 0);
    chk({tag, " fb_col"}, fb_col, 0);
    chk({tag, " fb_data"}, fb_data, 0);
  endtask

  initial begin
    bq_t q, pre, suf;
    wait_clks(3);
    check_reset_outputs("reset");
    @(posedge clk);
    reset = 1'b0;
    wait_clks(5);

    q = pkt(8'h03, 32'h11223344);
    send(q);
    model(q);
    compare("basic");

    uart_data = 1'b0;
    wait_clks(4);
    uart_data = 1'b1;
    wait_clks(2 * CPB);
    q = {8'h00, 8'h7E};
    app(q, pkt(8'h00, 32'hA5A5A5A5));
    send(q);
    model(q);
    compare("junk+sync data");

    q = {8'hA5, 8'h08};
    app(q, pkt(8'h07, 32'h01020304));
    send(q);
    model(q);
    compare("bad row");

    q = pkt(8'h04, 32'h11AABBCC);
    pre = {q[0], q[1], q[2]};
    send(pre);
    model(pre);
    uart_data = 1'b0;
    wait_clks(15 * CPB);
    uart_data = 1'b1;
    wait_clks(2 * CPB);
    exp_err++;
    q = pkt(8'h01, 32'hDEADBEEF);
    send(q);
    model(q);
    compare("break");

    q = pkt(8'h02, 32'h10203344);
    pre = {q[0], q[1], q[2], q[3]};
    suf.delete();
    for (int i = 4; i < q.size(); i++) suf.push_back(q[i]);
    send(pre);
    model(pre);
    wait_clks(2);
    reset = 1'b1;
    wait_clks(3);
    check_reset_outputs("midreset");
    @(posedge clk);
    reset = 1'b0;
    wait_clks(5);
    send(suf);
    model(suf);
    compare("midreset");

`ifdef LED_UART_CHECKSUM_EN
    q = {8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    send(q);
    model(q);
    compare("csum bad");
`endif

    for (int b = 0; b < 3; b++) begin
      q.delete();
      for (int p = 0; p < 5; p++) begin
        logic [7:0] j, r;
        if ($urandom_range(0, 3) == 0) begin
          j = 8'($urandom_range(0, 255));
          q.push_back(j == 8'hA5 ? 8'h5A : j);
        end
        r = 8'($urandom_range(0, 9));
        if (r >= ROWS) q = {q, 8'hA5, r};
        else begin
          pre = pkt(r, $urandom);
`ifdef LED_UART_CHECKSUM_EN
          if ($urandom_range(0, 3) == 0) pre[pre.size()-1] ^= 8'h01;
`endif
          app(q, pre);
        end
      end
      send(q);
      model(q);
      compare("random");
    end

    chk("row_done timing", rd_bad, 0);
`ifdef LED_UART_CHECKSUM_EN
    chk("write burst", max_run, RB);
`else
    chk("write burst", max_run, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
